// File: rtl/ct_had_xtrig_pkg.sv
// Shared types and defaults for the HAD cross-trigger matrix.
package ct_had_xtrig_pkg;

  typedef enum logic [1:0] {
    XT_IDLE  = 2'b00,
    XT_ENTER = 2'b01,
    XT_EXIT  = 2'b10
  } xtrig_state_e;

  localparam int XTRIG_TMO_W_DFLT = 8;

endpackage

// File: rtl/ct_had_xtrig_matrix_if.sv
// Core-side and debug-register-side signals of the cross-trigger matrix.
interface ct_had_xtrig_matrix_if #(
  parameter int NUM_CORES = 4,
  parameter int TMO_W     = 8
) ();

  // Handshake: a core reports entry/exit with a one-cycle *_dbg_req_o pulse.
  // The matrix answers with a level *_dbg_req_i that is held until the target
  // core's dbg_ack reaches the wanted level or the timeout expires.
  logic [NUM_CORES-1:0]      corex_enter_dbg_req_o;
  logic [NUM_CORES-1:0]      corex_exit_dbg_req_o;
  logic [NUM_CORES-1:0]      corex_dbg_ack;
  logic [NUM_CORES-1:0]      had_halt_grp_en;
  logic [NUM_CORES-1:0]      had_resume_grp_en;
  logic [TMO_W-1:0]          had_xtrig_tmo_cfg;
  logic                      had_xtrig_err_clr;
  logic [NUM_CORES-1:0]      corex_enter_dbg_req_i;
  logic [NUM_CORES-1:0]      corex_exit_dbg_req_i;
  logic                      xtrig_busy;
  logic [NUM_CORES-1:0]      xtrig_tmo_err;
  logic [NUM_CORES-1:0][1:0] chan_state_dbg;

  modport slave (
    input  corex_enter_dbg_req_o, corex_exit_dbg_req_o, corex_dbg_ack,
    input  had_halt_grp_en, had_resume_grp_en, had_xtrig_tmo_cfg, had_xtrig_err_clr,
    output corex_enter_dbg_req_i, corex_exit_dbg_req_i, xtrig_busy, xtrig_tmo_err,
    output chan_state_dbg
  );

  modport master (
    output corex_enter_dbg_req_o, corex_exit_dbg_req_o, corex_dbg_ack,
    output had_halt_grp_en, had_resume_grp_en, had_xtrig_tmo_cfg, had_xtrig_err_clr,
    input  corex_enter_dbg_req_i, corex_exit_dbg_req_i, xtrig_busy, xtrig_tmo_err,
    input  chan_state_dbg
  );

endinterface

// File: rtl/ct_had_xtrig_chan.sv
// One cross-trigger channel: request FSM, timeout counter and sticky error flag.
module ct_had_xtrig_chan
  import ct_had_xtrig_pkg::*;
#(
  parameter int TMO_W = XTRIG_TMO_W_DFLT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enter_hit_i,
  input  logic             exit_hit_i,
  input  logic             dbg_ack_i,
  input  logic [TMO_W-1:0] cfg_i,
  input  logic             err_clr_i,
  output logic             enter_req_o,
  output logic             exit_req_o,
  output logic             busy_o,
  output logic             tmo_err_o,
  output xtrig_state_e     state_o
);

  xtrig_state_e     state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo;
  logic             err_set;

  // Counter reaches cfg-1 on the last of cfg request cycles.
  assign tmo = (cfg_i != '0) && (cnt_q == (cfg_i - TMO_W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
    err_set = 1'b0;
    case (state_q)
      XT_IDLE: begin
        cnt_d = '0;
        if (enter_hit_i)     state_d = XT_ENTER;
        else if (exit_hit_i) state_d = XT_EXIT;
      end
      XT_ENTER: begin
        if (dbg_ack_i) begin
          state_d = XT_IDLE;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = XT_IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end
      end
      XT_EXIT: begin
        // A fresh halt request overrides a pending resume and restarts timing.
        if (enter_hit_i) begin
          state_d = XT_ENTER;
          cnt_d   = '0;
        end else if (!dbg_ack_i) begin
          state_d = XT_IDLE;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = XT_IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = XT_IDLE;
        cnt_d   = '0;
      end
    endcase
    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= XT_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign enter_req_o = (state_q == XT_ENTER);
  assign exit_req_o  = (state_q == XT_EXIT);
  assign busy_o      = (state_q != XT_IDLE);
  assign tmo_err_o   = err_q;
  assign state_o     = state_q;

endmodule

// File: rtl/ct_had_xtrig_matrix.sv
// Cross-trigger matrix: group-filtered hit decode feeding one channel per core.
module ct_had_xtrig_matrix
  import ct_had_xtrig_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TMO_W     = XTRIG_TMO_W_DFLT
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  ct_had_xtrig_matrix_if.slave  bus
);

  logic [NUM_CORES-1:0] enter_src, exit_src;
  logic [NUM_CORES-1:0] enter_hit, exit_hit;
  logic [NUM_CORES-1:0] others;
  logic [NUM_CORES-1:0] enter_req, exit_req, busy, tmo_err;
  xtrig_state_e         chan_state [NUM_CORES];

  assign enter_src = bus.corex_enter_dbg_req_o & bus.had_halt_grp_en;
  assign exit_src  = bus.corex_exit_dbg_req_o  & bus.had_resume_grp_en;

  // A channel is triggered only by another member of its own group.
  always_comb begin
    enter_hit = '0;
    exit_hit  = '0;
    others    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      others    = '1;
      others[i] = 1'b0;
      enter_hit[i] = bus.had_halt_grp_en[i] & ~bus.corex_dbg_ack[i] & |(enter_src & others);
      exit_hit[i]  = bus.had_resume_grp_en[i] & bus.corex_dbg_ack[i] & |(exit_src & others);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_chan
    ct_had_xtrig_chan #(.TMO_W(TMO_W)) u_chan (
      .clk_i       (forever_cpuclk),
      .rst_i       (cpurst),
      .enter_hit_i (enter_hit[g]),
      .exit_hit_i  (exit_hit[g]),
      .dbg_ack_i   (bus.corex_dbg_ack[g]),
      .cfg_i       (bus.had_xtrig_tmo_cfg),
      .err_clr_i   (bus.had_xtrig_err_clr),
      .enter_req_o (enter_req[g]),
      .exit_req_o  (exit_req[g]),
      .busy_o      (busy[g]),
      .tmo_err_o   (tmo_err[g]),
      .state_o     (chan_state[g])
    );
    assign bus.chan_state_dbg[g] = chan_state[g];
  end

  assign bus.corex_enter_dbg_req_i = enter_req;
  assign bus.corex_exit_dbg_req_i  = exit_req;
  assign bus.xtrig_busy            = |busy;
  assign bus.xtrig_tmo_err         = tmo_err;

endmodule

// File: tb/tb_ct_had_xtrig_matrix.sv
// Directed bench for the cross-trigger matrix with hand-computed expectations.
module tb_ct_had_xtrig_matrix;

  localparam int NC = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ct_had_xtrig_matrix_if #(.NUM_CORES(NC), .TMO_W(TW)) xif ();

  ct_had_xtrig_matrix #(.NUM_CORES(NC), .TMO_W(TW)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (xif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_pulse(input logic [NC-1:0] src);
    xif.corex_enter_dbg_req_o = src;
    step();
    xif.corex_enter_dbg_req_o = '0;
  endtask

  task automatic exit_pulse(input logic [NC-1:0] src);
    xif.corex_exit_dbg_req_o = src;
    step();
    xif.corex_exit_dbg_req_o = '0;
  endtask

  initial begin
    xif.corex_enter_dbg_req_o = '0;
    xif.corex_exit_dbg_req_o  = '0;
    xif.corex_dbg_ack         = '0;
    xif.had_halt_grp_en       = '0;
    xif.had_resume_grp_en     = '0;
    xif.had_xtrig_tmo_cfg     = '0;
    xif.had_xtrig_err_clr     = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_enter_req", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("rst_exit_req",  32'(xif.corex_exit_dbg_req_i),  32'h0);
    chk("rst_busy",      32'(xif.xtrig_busy),            32'h0);
    chk("rst_tmo_err",   32'(xif.xtrig_tmo_err),         32'h0);
    rst = 1'b0;
    step();

    // Full halt group, core0 enters
    xif.had_halt_grp_en = 4'b1111;
    enter_pulse(4'b0001);
    chk("t1_req",  32'(xif.corex_enter_dbg_req_i), 32'hE);
    chk("t1_busy", 32'(xif.xtrig_busy),            32'h1);
    repeat (3) step();
    chk("t1_hold", 32'(xif.corex_enter_dbg_req_i), 32'hE);
    xif.corex_dbg_ack = 4'b0100;
    step();
    chk("t1_ack2", 32'(xif.corex_enter_dbg_req_i), 32'hA);
    xif.corex_dbg_ack = 4'b1110;
    step();
    chk("t1_done", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t1_idle", 32'(xif.xtrig_busy),            32'h0);
    xif.corex_dbg_ack = '0;
    step();

    // Partial halt group: outsider triggers nothing
    xif.had_halt_grp_en = 4'b0011;
    enter_pulse(4'b0100);
    chk("t2_outsider", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t2_out_busy", 32'(xif.xtrig_busy),            32'h0);
    enter_pulse(4'b0001);
    chk("t2_member", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    xif.corex_dbg_ack = 4'b0010;
    step();
    chk("t2_ack", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    xif.corex_dbg_ack = '0;
    step();

    // Timeout of 5 cycles on channel1
    xif.had_xtrig_tmo_cfg = 8'd5;
    enter_pulse(4'b0001);
    chk("t3_req_c1", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    chk("t3_err_c1", 32'(xif.xtrig_tmo_err),         32'h0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("t3_req_c%0d", k), 32'(xif.corex_enter_dbg_req_i), 32'h2);
    end
    step();
    chk("t3_tmo_drop", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t3_tmo_err",  32'(xif.xtrig_tmo_err),         32'h2);
    chk("t3_tmo_busy", 32'(xif.xtrig_busy),            32'h0);

    // Clear coincident with a new timeout: set wins
    enter_pulse(4'b0001);
    chk("t3b_req", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    repeat (4) step();
    xif.had_xtrig_err_clr = 1'b1;
    step();
    xif.had_xtrig_err_clr = 1'b0;
    chk("t3b_drop",    32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t3b_set_win", 32'(xif.xtrig_tmo_err),         32'h2);
    xif.had_xtrig_err_clr = 1'b1;
    step();
    xif.had_xtrig_err_clr = 1'b0;
    chk("t3b_clr", 32'(xif.xtrig_tmo_err), 32'h0);

    // Ack in the timeout cycle: ack wins, no error
    enter_pulse(4'b0001);
    repeat (4) step();
    xif.corex_dbg_ack = 4'b0010;
    step();
    chk("t3c_drop", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t3c_err",  32'(xif.xtrig_tmo_err),         32'h0);
    xif.corex_dbg_ack = '0;
    step();

    // Resume group, core3 exits
    xif.had_xtrig_tmo_cfg = '0;
    xif.had_halt_grp_en   = '0;
    xif.had_resume_grp_en = 4'b1111;
    xif.corex_dbg_ack     = 4'b1111;
    step();
    exit_pulse(4'b1000);
    chk("t4_req", 32'(xif.corex_exit_dbg_req_i), 32'h7);
    xif.corex_dbg_ack = 4'b1110;
    step();
    chk("t4_drop0", 32'(xif.corex_exit_dbg_req_i), 32'h6);
    xif.corex_dbg_ack = 4'b1010;
    step();
    chk("t4_drop2", 32'(xif.corex_exit_dbg_req_i), 32'h2);
    xif.corex_dbg_ack = 4'b1000;
    step();
    chk("t4_done", 32'(xif.corex_exit_dbg_req_i), 32'h0);
    chk("t4_busy", 32'(xif.xtrig_busy),           32'h0);

    // Enter preempts a pending exit and restarts the counter
    xif.had_halt_grp_en   = 4'b0011;
    xif.had_resume_grp_en = 4'b0011;
    xif.had_xtrig_tmo_cfg = 8'd6;
    xif.corex_dbg_ack     = 4'b1111;
    exit_pulse(4'b0001);
    chk("t5_exit", 32'(xif.corex_exit_dbg_req_i), 32'h2);
    repeat (2) step();
    xif.corex_dbg_ack = 4'b1101;
    enter_pulse(4'b0001);
    chk("t5_pre_enter", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    chk("t5_pre_exit",  32'(xif.corex_exit_dbg_req_i),  32'h0);
    chk("t5_state1",    32'(xif.chan_state_dbg[1]),     32'h1);
    repeat (5) step();
    chk("t5_restart_hold", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    step();
    chk("t5_tmo_drop", 32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t5_tmo_err",  32'(xif.xtrig_tmo_err),         32'h2);
    xif.had_xtrig_err_clr = 1'b1;
    step();
    xif.had_xtrig_err_clr = 1'b0;
    chk("t5_clr", 32'(xif.xtrig_tmo_err), 32'h0);

    // Simultaneous enter and exit pulses from IDLE resolve to ENTER
    xif.had_xtrig_tmo_cfg     = '0;
    xif.corex_enter_dbg_req_o = 4'b0001;
    xif.corex_exit_dbg_req_o  = 4'b0001;
    step();
    xif.corex_enter_dbg_req_o = '0;
    xif.corex_exit_dbg_req_o  = '0;
    chk("t5b_enter", 32'(xif.corex_enter_dbg_req_i), 32'h2);
    chk("t5b_exit",  32'(xif.corex_exit_dbg_req_i),  32'h0);
    xif.corex_dbg_ack = 4'b1111;
    step();
    chk("t5b_done", 32'(xif.corex_enter_dbg_req_i), 32'h0);

    // Asynchronous reset with three pending requests
    xif.corex_dbg_ack   = '0;
    xif.had_halt_grp_en = 4'b1111;
    step();
    enter_pulse(4'b0001);
    chk("t6_pending", 32'(xif.corex_enter_dbg_req_i), 32'hE);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_req",  32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t6_rst_busy", 32'(xif.xtrig_busy),            32'h0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("t6_post_req",  32'(xif.corex_enter_dbg_req_i), 32'h0);
    chk("t6_post_busy", 32'(xif.xtrig_busy),            32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
